// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key constants, FSM encoding and debounce defaults
package keypad_pkg;

    localparam int KEY_W                   = 12;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 20000;

    localparam logic [KEY_W-1:0] KEY_1    = 12'h001;
    localparam logic [KEY_W-1:0] KEY_2    = 12'h002;
    localparam logic [KEY_W-1:0] KEY_3    = 12'h004;
    localparam logic [KEY_W-1:0] KEY_4    = 12'h008;
    localparam logic [KEY_W-1:0] KEY_5    = 12'h010;
    localparam logic [KEY_W-1:0] KEY_6    = 12'h020;
    localparam logic [KEY_W-1:0] KEY_7    = 12'h040;
    localparam logic [KEY_W-1:0] KEY_8    = 12'h080;
    localparam logic [KEY_W-1:0] KEY_9    = 12'h100;
    localparam logic [KEY_W-1:0] KEY_STAR = 12'h200;
    localparam logic [KEY_W-1:0] KEY_0    = 12'h400;
    localparam logic [KEY_W-1:0] KEY_HASH = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
        logic [KEY_W-1:0] v_minus_one;
        v_minus_one = v - 12'd1;
        return (v != '0) && ((v & v_minus_one) == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - single-key keypad debouncer with multi-key rejection
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  Keypad_in,
    output logic [KEY_W-1:0]  Key_out,
    output logic              valid,
    output logic              pressed,
    output logic              multi_err
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [KEY_W-1:0] sync;

    state_e           state_d, state_q;
    logic [KEY_W-1:0] cand_d, cand_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [KEY_W-1:0] key_d, key_q;
    logic             valid_d, valid_q;
    logic             pressed_d, pressed_q;
    logic             merr_d, merr_q;
    logic [CNT_W-1:0] cnt_inc;

    sync_2ff #(
        .WIDTH (KEY_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Keypad_in),
        .q   (sync)
    );

    // Saturating increment: the counter parks at CNT_MAX instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        merr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync != '0) begin
                    cand_d  = sync;
                    cnt_d   = CNT_ONE;
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (sync == '0) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = CNT_ONE;
                end else if (cnt_inc == CNT_MAX) begin
                    cnt_d = '0;
                    if (is_one_hot(cand_q)) begin
                        key_d   = cand_q;
                        valid_d = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        merr_d  = 1'b1;
                        state_d = ST_RELEASE_WAIT;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (sync != key_q) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                // Any key activity restarts the release window, so roll-over needs a full release.
                if (sync != '0) begin
                    cnt_d = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    cnt_d   = '0;
                    key_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pressed_d = (state_d == ST_HELD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
            merr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
            merr_q    <= merr_d;
        end
    end

    assign Key_out   = key_q;
    assign valid     = valid_q;
    assign pressed   = pressed_q;
    assign multi_err = merr_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// tb/tb_keypad_debounce.sv - table and sequence driven scoreboard bench for keypad_debounce
module tb_keypad_debounce;

    localparam int D = 4;

    typedef struct packed {
        logic [11:0] key;
        logic        v;
        logic        p;
        logic        m;
    } obs_t;

    typedef struct {
        logic [11:0] key;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] Keypad_in = '0;
    logic [11:0] Key_out;
    logic        valid;
    logic        pressed;
    logic        multi_err;

    int   checks   = 0;
    int   failures = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Keypad_in (Keypad_in),
        .Key_out   (Key_out),
        .valid     (valid),
        .pressed   (pressed),
        .multi_err (multi_err)
    );

    function automatic obs_t mk(logic [11:0] k, logic v, logic p, logic m);
        obs_t o;
        o = {k, v, p, m};
        return o;
    endfunction

    // Drive one cycle of input, queue the output expected after the next edge, then check it.
    task automatic step(input logic [11:0] k, input logic r, input obs_t e, input string tag, input int n);
        obs_t got;
        obs_t want;
        Keypad_in = k;
        rst       = r;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {Key_out, valid, pressed, multi_err};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s n=%0d: scoreboard empty", tag, n);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s n=%0d: got key=%h valid=%b pressed=%b multi_err=%b, want key=%h valid=%b pressed=%b multi_err=%b",
                         tag, n, got.key, got.v, got.p, got.m, want.key, want.v, want.p, want.m);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [11:0] k;
        logic        acc;
        logic        oh;
        int          n;

        vecs[0] = '{12'h010, 20};
        vecs[1] = '{12'h001, 3};
        vecs[2] = '{12'h800, 4};
        vecs[3] = '{12'h011, 10};
        vecs[4] = '{12'h000, 6};
        vecs[5] = '{12'h400, 5};
        vecs[6] = '{12'h007, 6};
        vecs[7] = '{12'h200, 8};
        vecs[8] = '{12'h003, 3};
        vecs[9] = '{12'h004, 3};

        for (int c = 0; c < 3; c++) step(12'hFFF, 1'b1, mk(12'h000, 0, 0, 0), "reset_hold", c + 1);
        for (int c = 0; c < 4; c++) step(12'h000, 1'b0, mk(12'h000, 0, 0, 0), "reset_idle", c + 1);

        for (int i = 0; i < 10; i++) begin
            acc = (vecs[i].hold >= D) && (vecs[i].key != 12'h000);
            oh  = ($countones(vecs[i].key) == 1);
            for (int c = 0; c < vecs[i].hold + 10; c++) begin
                n = c + 1;
                k = (c < vecs[i].hold) ? vecs[i].key : 12'h000;
                step(k, 1'b0,
                     mk((acc && oh && n >= 6 && n < vecs[i].hold + 7) ? vecs[i].key : 12'h000,
                        acc && oh && n == 6,
                        acc && oh && n >= 6 && n < vecs[i].hold + 3,
                        acc && !oh && n == 6),
                     $sformatf("vec%0d", i), n);
            end
        end

        for (int c = 0; c < 30; c++) begin
            n = c + 1;
            if (c < 10) k = ((c / 2) % 2 == 0) ? 12'h010 : 12'h000;
            else        k = (c < 20) ? 12'h010 : 12'h000;
            step(k, 1'b0, mk((n >= 14 && n < 27) ? 12'h010 : 12'h000, n == 14, n >= 14 && n < 23, 1'b0),
                 "bounce", n);
        end

        for (int c = 0; c < 70; c++) begin
            n = c + 1;
            if (c < 10)      k = 12'h011;
            else if (c < 30) k = 12'h001;
            else if (c < 40) k = 12'h000;
            else if (c < 60) k = 12'h001;
            else             k = 12'h000;
            step(k, 1'b0, mk((n >= 46 && n < 67) ? 12'h001 : 12'h000, n == 46, n >= 46 && n < 63, n == 6),
                 "multi_key", n);
        end

        for (int c = 0; c < 60; c++) begin
            n = c + 1;
            if (c < 10)      k = 12'h001;
            else if (c < 20) k = 12'h003;
            else if (c < 30) k = 12'h000;
            else if (c < 50) k = 12'h001;
            else             k = 12'h000;
            step(k, 1'b0,
                 mk(((n >= 6 && n < 26) || (n >= 36 && n < 57)) ? 12'h001 : 12'h000,
                    n == 6 || n == 36,
                    (n >= 6 && n < 13) || (n >= 36 && n < 53),
                    1'b0),
                 "rollover", n);
        end

        for (int c = 0; c < 30; c++) begin
            n = c + 1;
            k = (c < 20) ? 12'h800 : 12'h000;
            step(k, c == 4, mk((n >= 11 && n < 27) ? 12'h800 : 12'h000, n == 11, n >= 11 && n < 23, 1'b0),
                 "reset_mid_debounce", n);
        end

        for (int c = 0; c < 30; c++) begin
            n = c + 1;
            k = (c < 20) ? 12'h020 : 12'h000;
            step(k, c == 8,
                 mk(((n >= 6 && n < 9) || (n >= 15 && n < 27)) ? 12'h020 : 12'h000,
                    n == 6 || n == 15,
                    (n >= 6 && n < 9) || (n >= 15 && n < 23),
                    1'b0),
                 "reset_in_held", n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
